// File: rtl/alu_op_driver_pkg.sv
// Package: alu_op_driver_pkg
// Purpose: shared widths, FSM state type, ALU opcode constants and a latency
//          helper for the ALU operation driver and its command queue.
package alu_op_driver_pkg;

    // Default datapath widths; DATA_W/CTRL_W must match the attached ALU.
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned CTRL_W_DEF      = 4;
    localparam int unsigned TAG_W_DEF       = 4;
    localparam int unsigned FIFO_DEPTH_DEF  = 4;
    localparam int unsigned ALU_LATENCY_DEF = 1;

    // Latency counter covers ALU_LATENCY range 1..15.
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OPS_W = 16;

    // ALU opcodes used by the host side.
    localparam logic [3:0] OP_0 = 4'b0000;
    localparam logic [3:0] OP_4 = 4'b0100;
    localparam logic [3:0] OP_8 = 4'b1000;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StResp
    } state_e;

    // Clamp a latency parameter into the range the wait counter can express.
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        if (lat < 1) begin
            return CNT_W'(1);
        end else if (lat > (2 ** CNT_W) - 1) begin
            return CNT_W'((2 ** CNT_W) - 1);
        end
        return CNT_W'(lat);
    endfunction

endpackage

// File: rtl/alu_op_driver_if.sv
// Interface: alu_op_driver_if
// Purpose: host-side command and response channels of the ALU operation driver.
//   cmd_*  : host -> driver, valid/ready, carries operands, opcode and tag
//   rsp_*  : driver -> host, valid/ready, carries captured answer, opcode and tag
// Modports: master = host/sequencer, slave = alu_op_driver.
interface alu_op_driver_if
    import alu_op_driver_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [CTRL_W-1:0] cmd_ctrl;
    logic [TAG_W-1:0]  cmd_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_answer;
    logic [CTRL_W-1:0] rsp_ctrl;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_ctrl, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_answer, rsp_ctrl, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_ctrl, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_answer, rsp_ctrl, rsp_tag,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_op_driver_cmd_fifo.sv
// Module: alu_op_driver_cmd_fifo
// Purpose: synchronous command queue of packed {tag, ctrl, b, a} entries.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the queue)
//   push, wdata   : write request and entry; ignored while full
//   pop           : advance read pointer; ignored while empty
//   rdata         : head entry (valid while !empty)
//   full, empty   : occupancy flags, derived from registered pointers only
module alu_op_driver_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty when indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/alu_op_driver.sv
// Module: alu_op_driver
// Purpose: initiator for a clocked ALU. Queues host commands, issues them one at
//          a time on alu_a/alu_b/alu_control, waits the ALU latency, captures the
//          answer and returns it with its opcode and tag on the response channel.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   host          : cmd/rsp valid/ready channels (slave side)
//   alu_a/b       : operands to ALU, held from issue until the next issue
//   alu_control   : opcode to ALU
//   alu_answer    : result from ALU
//   ops_done      : completed-operation count, wraps at 16 bits
//   busy          : FSM active or commands still queued
module alu_op_driver
    import alu_op_driver_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned CTRL_W      = CTRL_W_DEF,
    parameter int unsigned TAG_W       = TAG_W_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned ALU_LATENCY = ALU_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_driver_if.slave    host,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_answer,
    output logic [OPS_W-1:0]  ops_done,
    output logic              busy
);

    localparam int unsigned    ENTRY_W  = TAG_W + CTRL_W + 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAT_LD = lat_load(ALU_LATENCY);

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    state_e             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;
    logic [CTRL_W-1:0]  alu_control_q;
    logic [TAG_W-1:0]   issue_tag_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_answer_q;
    logic [CTRL_W-1:0]  rsp_ctrl_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [OPS_W-1:0]   ops_done_q;

    // Command queue
    assign fifo_push  = host.cmd_valid && !fifo_full;
    assign fifo_pop   = (state_q == StIssue);
    assign fifo_wdata = {host.cmd_tag, host.cmd_ctrl, host.cmd_b, host.cmd_a};

    alu_op_driver_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Control FSM with registered datapath outputs. ISSUE is only entered with
    // a non-empty queue, so the pop there always takes the head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            issue_tag_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_answer_q  <= '0;
            rsp_ctrl_q    <= '0;
            rsp_tag_q     <= '0;
            ops_done_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    {issue_tag_q, alu_control_q, alu_b_q, alu_a_q} <= fifo_rdata;
                    wait_cnt_q <= LAT_LD;
                    state_q    <= StWait;
                end
                StWait: begin
                    // Leaving on the edge where the count hits zero keeps WAIT at
                    // exactly ALU_LATENCY cycles.
                    wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    if (wait_cnt_q == CNT_W'(1)) begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    rsp_answer_q <= alu_answer;
                    rsp_ctrl_q   <= alu_control_q;
                    rsp_tag_q    <= issue_tag_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + OPS_W'(1);
                        state_q     <= fifo_empty ? StIdle : StIssue;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign host.cmd_ready  = !fifo_full;
    assign host.rsp_valid  = rsp_valid_q;
    assign host.rsp_answer = rsp_answer_q;
    assign host.rsp_ctrl   = rsp_ctrl_q;
    assign host.rsp_tag    = rsp_tag_q;

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;
    assign ops_done    = ops_done_q;
    assign busy        = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: two instances (ALU latency 1 and 3), each attached to
// an XOR ALU stub whose Answer is A^B delayed by the configured latency.
module tb_alu_op_driver;
    import alu_op_driver_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_driver_if h1 ();
    alu_op_driver_if h3 ();

    logic [15:0] a1, b1, ans1, ops1;
    logic [3:0]  c1;
    logic        busy1;
    logic [15:0] a3, b3, ans3, ops3;
    logic [3:0]  c3;
    logic        busy3;
    logic [15:0] p3 [3];

    alu_op_driver #(.ALU_LATENCY(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .host        (h1),
        .alu_a       (a1),
        .alu_b       (b1),
        .alu_control (c1),
        .alu_answer  (ans1),
        .ops_done    (ops1),
        .busy        (busy1)
    );

    alu_op_driver #(.ALU_LATENCY(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .host        (h3),
        .alu_a       (a3),
        .alu_b       (b3),
        .alu_control (c3),
        .alu_answer  (ans3),
        .ops_done    (ops3),
        .busy        (busy3)
    );

    // ALU stubs
    always_ff @(posedge clk) ans1 <= a1 ^ b1;
    always_ff @(posedge clk) begin
        p3[0] <= a3 ^ b3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ans3 = p3[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp1(output int n);
        n = 0;
        while (!h1.rsp_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Test 2 vectors with hand-computed XOR results.
    logic [15:0] t2_a   [5] = '{16'h00FF, 16'h1234, 16'hAAAA, 16'h0F0F, 16'hFFFF};
    logic [15:0] t2_b   [5] = '{16'h0F00, 16'h4321, 16'h5555, 16'h0F0F, 16'h0001};
    logic [15:0] t2_exp [5] = '{16'h0FFF, 16'h5115, 16'hFFFF, 16'h0000, 16'hFFFE};
    logic [3:0]  t2_op  [5] = '{4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100};

    initial begin
        int n;
        int k;
        int extra;
        logic held;

        h1.cmd_valid = 1'b0; h1.cmd_a = '0; h1.cmd_b = '0; h1.cmd_ctrl = '0;
        h1.cmd_tag = '0; h1.rsp_ready = 1'b0;
        h3.cmd_valid = 1'b0; h3.cmd_a = '0; h3.cmd_b = '0; h3.cmd_ctrl = '0;
        h3.cmd_tag = '0; h3.rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_cmd_ready", 32'(h1.cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(h1.rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy1), 32'd0);
        check_eq("rst_ops_done", 32'(ops1), 32'd0);
        check_eq("rst_alu_a", 32'(a1), 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: single op, rsp_valid on the 5th edge counting the accepting one
        h1.cmd_a = 16'd10; h1.cmd_b = 16'd20; h1.cmd_ctrl = OP_4; h1.cmd_tag = 4'd1;
        h1.cmd_valid = 1'b1; h1.rsp_ready = 1'b1;
        check_eq("t1_cmd_ready", 32'(h1.cmd_ready), 32'd1);
        tick();
        h1.cmd_valid = 1'b0;
        wait_rsp1(n);
        check_eq("t1_latency", 32'(n), 32'd4);
        check_eq("t1_answer", 32'(h1.rsp_answer), 32'd30);
        check_eq("t1_tag", 32'(h1.rsp_tag), 32'd1);
        check_eq("t1_ctrl", 32'(h1.rsp_ctrl), 32'(OP_4));
        tick();
        check_eq("t1_ops_done", 32'(ops1), 32'd1);
        check_eq("t1_rsp_drop", 32'(h1.rsp_valid), 32'd0);
        check_eq("t1_idle", 32'(busy1), 32'd0);
        check_eq("t1_alu_a_held", 32'(a1), 32'd10);

        // Test 4: latency 3, issue->capture spans IDLE+ISSUE+3 WAIT+CAPTURE edges
        h3.cmd_a = 16'd30; h3.cmd_b = 16'd9; h3.cmd_ctrl = OP_8; h3.cmd_tag = 4'd7;
        h3.cmd_valid = 1'b1; h3.rsp_ready = 1'b1;
        tick();
        h3.cmd_valid = 1'b0;
        n = 0;
        while (!h3.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq("t4_latency", 32'(n), 32'd6);
        check_eq("t4_answer", 32'(h3.rsp_answer), 32'd23);
        check_eq("t4_tag", 32'(h3.rsp_tag), 32'd7);
        tick();
        check_eq("t4_ops_done", 32'(ops3), 32'd1);

        // Test 2/3: five back-to-back commands with the response side stalled
        h1.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            h1.cmd_a = t2_a[i]; h1.cmd_b = t2_b[i]; h1.cmd_ctrl = t2_op[i];
            h1.cmd_tag = 4'(i); h1.cmd_valid = 1'b1;
            n = 0;
            while (!h1.cmd_ready && n < 20) begin
                tick();
                n++;
            end
            check_eq("t2_push_ready", 32'(h1.cmd_ready), 32'd1);
            tick();
        end
        h1.cmd_valid = 1'b0;
        check_eq("t2_full", 32'(h1.cmd_ready), 32'd0);
        wait_rsp1(n);
        check_eq("t2_first_rsp", 32'(h1.rsp_valid), 32'd1);

        // Stall 10 cycles while offering a command that must be refused
        h1.cmd_a = 16'hDEAD; h1.cmd_b = 16'h0000; h1.cmd_tag = 4'd15; h1.cmd_valid = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            held &= h1.rsp_valid && (h1.rsp_tag == 4'd0) && (h1.rsp_answer == 16'h0FFF) &&
                    (a1 == 16'h00FF) && !h1.cmd_ready;
        end
        check_eq("t3_stall_hold", 32'(held), 32'd1);
        h1.cmd_valid = 1'b0;

        h1.rsp_ready = 1'b1;
        k = 0;
        n = 0;
        while (k < 5 && n < 100) begin
            if (h1.rsp_valid) begin
                check_eq($sformatf("t2_tag%0d", k), 32'(h1.rsp_tag), 32'(k));
                check_eq($sformatf("t2_ans%0d", k), 32'(h1.rsp_answer), 32'(t2_exp[k]));
                check_eq($sformatf("t2_ctrl%0d", k), 32'(h1.rsp_ctrl), 32'(t2_op[k]));
                k++;
            end
            tick();
            n++;
        end
        check_eq("t2_rsp_count", 32'(k), 32'd5);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (h1.rsp_valid) extra++;
            tick();
        end
        check_eq("t2_no_extra", 32'(extra), 32'd0);
        check_eq("t2_ops_done", 32'(ops1), 32'd6);
        check_eq("t2_busy", 32'(busy1), 32'd0);
        check_eq("t2_ready_back", 32'(h1.cmd_ready), 32'd1);

        // Test 5: reset while in WAIT with two commands still queued
        for (int i = 0; i < 3; i++) begin
            h1.cmd_a = 16'(i + 1); h1.cmd_b = 16'h0100; h1.cmd_ctrl = OP_4;
            h1.cmd_tag = 4'(8 + i); h1.cmd_valid = 1'b1;
            tick();
        end
        h1.cmd_valid = 1'b0;
        check_eq("t5_pre_busy", 32'(busy1), 32'd1);
        check_eq("t5_pre_rsp", 32'(h1.rsp_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_rsp_valid", 32'(h1.rsp_valid), 32'd0);
        check_eq("t5_cmd_ready", 32'(h1.cmd_ready), 32'd1);
        check_eq("t5_busy", 32'(busy1), 32'd0);
        check_eq("t5_ops_done", 32'(ops1), 32'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (h1.rsp_valid) extra++;
        end
        check_eq("t5_no_rsp", 32'(extra), 32'd0);
        check_eq("t5_busy_after", 32'(busy1), 32'd0);

        // Test 6: ops_done wraps from 16'hFFFF to 0
        force u_dut1.ops_done_q = 16'hFFFF;
        tick();
        release u_dut1.ops_done_q;
        tick();
        check_eq("t6_preload", 32'(ops1), 32'hFFFF);
        h1.cmd_a = 16'd1; h1.cmd_b = 16'd2; h1.cmd_ctrl = OP_8; h1.cmd_tag = 4'd3;
        h1.cmd_valid = 1'b1;
        tick();
        h1.cmd_valid = 1'b0;
        wait_rsp1(n);
        check_eq("t6_answer", 32'(h1.rsp_answer), 32'd3);
        tick();
        check_eq("t6_wrap", 32'(ops1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
